// File: rtl/fir_coef_loader.sv
// fir_coef_loader: streams a full bank of FIR coefficients into a shadow
// bank and commits it to the active bank in one step, when the FIR allows it.
// A bank with the wrong length is rejected, so the FIR never sees a partial bank.
// Optional feature: define FIR_COEF_CHECKSUM_EN to get a 16-bit modular sum
// of the committed bank on `checksum`. Without it, `checksum` is tied to 0.
module fir_coef_loader #(
  parameter int TAPS     = 401,
  parameter int COEFBITS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [COEFBITS-1:0] s_coef,
  input  logic                       s_last,
  input  logic                       swap_ok,
  output logic signed [COEFBITS-1:0] weights [0:TAPS-1],
  output logic                       coef_valid,
  output logic                       coef_update,
  output logic                       load_err,
  output logic [15:0]                checksum
);

  localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TAPS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SWAP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [COEFBITS-1:0] shadow_q [0:TAPS-1];
  logic signed [COEFBITS-1:0] shadow_d [0:TAPS-1];
  logic signed [COEFBITS-1:0] active_q [0:TAPS-1];
  logic signed [COEFBITS-1:0] active_d [0:TAPS-1];
  logic                       coef_valid_q, coef_valid_d;
  logic                       coef_update_q, coef_update_d;
  logic                       load_err_q, load_err_d;

  logic beat_acc;
  logic first_beat;
  logic idx_at_max;
  logic commit_now;

  assign s_ready    = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign beat_acc   = s_valid && s_ready;
  assign first_beat = beat_acc && (state_q == S_IDLE);
  assign idx_at_max = (idx_q == IDX_MAX);
  assign commit_now = (state_q == S_SWAP) && swap_ok;

  assign weights     = active_q;
  assign coef_valid  = coef_valid_q;
  assign coef_update = coef_update_q;
  assign load_err    = load_err_q;

  // Load/commit FSM: fills the shadow bank, validates length, commits atomically.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    coef_valid_d  = coef_valid_q;
    coef_update_d = 1'b0;
    load_err_d    = load_err_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (beat_acc) begin
          shadow_d[idx_q] = s_coef;
          if (first_beat) load_err_d = 1'b0;
          if (s_last && idx_at_max) begin
            state_d = S_SWAP;
          end else if (s_last || idx_at_max) begin
            // Short load (early s_last) or long load (no s_last at the final
            // slot); idx is never advanced past the last slot.
            state_d = S_ERR;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_SWAP: begin
        if (swap_ok) begin
          active_d      = shadow_q;
          coef_valid_d  = 1'b1;
          coef_update_d = 1'b1;
          idx_d         = '0;
          state_d       = S_IDLE;
        end
      end
      S_ERR: begin
        load_err_d = 1'b1;
        idx_d      = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and bank registers; reset clears both banks so the FIR starts from zeros.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      shadow_q      <= '{default: '0};
      active_q      <= '{default: '0};
      coef_valid_q  <= 1'b0;
      coef_update_q <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      coef_valid_q  <= coef_valid_d;
      coef_update_q <= coef_update_d;
      load_err_q    <= load_err_d;
    end
  end

`ifdef FIR_COEF_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic [15:0] checksum_q, checksum_d;

  assign checksum = checksum_q;

  // Running sum of raw coefficient bits for the load in progress; latched on commit only.
  always_comb begin
    sum_d      = sum_q;
    checksum_d = checksum_q;
    if (beat_acc) sum_d = (first_beat ? 16'd0 : sum_q) + 16'($unsigned(s_coef));
    if (commit_now) checksum_d = sum_q;
  end

  // Checksum registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q      <= 16'd0;
      checksum_q <= 16'd0;
    end else begin
      sum_q      <= sum_d;
      checksum_q <= checksum_d;
    end
  end
`else
  assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader: directed bench for fir_coef_loader with TAPS=4.
// Stimulus queues the expected bank for each commit; a monitor compares it
// whenever coef_update pulses. FIR_COEF_CHECKSUM_EN selects the checksum expectation.
module tb_fir_coef_loader;

`ifdef FIR_COEF_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_coef;
  logic               s_last;
  logic               swap_ok;
  logic signed [15:0] weights [0:3];
  logic               coef_valid;
  logic               coef_update;
  logic               load_err;
  logic [15:0]        checksum;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0][15:0] w;
    logic [15:0]      ck;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;

  fir_coef_loader #(.TAPS(4), .COEFBITS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_coef     (s_coef),
    .s_last     (s_last),
    .swap_ok    (swap_ok),
    .weights    (weights),
    .coef_valid (coef_valid),
    .coef_update(coef_update),
    .load_err   (load_err),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  task automatic expect_commit(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] d,
                               input logic [15:0] ck);
    exp_t e;
    e.w[0] = a;
    e.w[1] = b;
    e.w[2] = c;
    e.w[3] = d;
    e.ck   = CK_EN ? ck : 16'd0;
    exp_q.push_back(e);
  endtask

  // Offer one beat and hold it until it is handshaked (bounded wait).
  task automatic beat(input logic [15:0] c, input logic l);
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_coef  = c;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("beat_handshake_timeout", 16'(n), 16'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every commit pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (coef_update === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("update_without_expectation", 16'(exp_q.size()), 16'd1);
      end else begin
        mon_e = exp_q.pop_front();
        for (int i = 0; i < 4; i++)
          chk($sformatf("commit_w%0d", i), weights[i], mon_e.w[i]);
        chk("commit_coef_valid", {15'd0, coef_valid}, 16'd1);
        chk("commit_checksum", checksum, mon_e.ck);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] vals [4];
    logic [15:0] pat;
    int          k;
    int          c;
    logic        acc;

    rst     = 1'b0;
    s_valid = 1'b0;
    s_coef  = '0;
    s_last  = 1'b0;
    swap_ok = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", {15'd0, s_ready}, 16'd1);
    chk("rst_coef_valid", {15'd0, coef_valid}, 16'd0);
    chk("rst_coef_update", {15'd0, coef_update}, 16'd0);
    chk("rst_load_err", {15'd0, load_err}, 16'd0);
    chk("rst_checksum", checksum, 16'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_w%0d", i), weights[i], 16'd0);
    rst = 1'b1;
    step();

    // Normal load 1,2,3,4
    expect_commit(16'd1, 16'd2, 16'd3, 16'd4, 16'd10);
    beat(16'd1, 1'b0);
    beat(16'd2, 1'b0);
    beat(16'd3, 1'b0);
    beat(16'd4, 1'b1);
    chk("swap_s_ready_low", {15'd0, s_ready}, 16'd0);
    step();
    chk("commit_latency_update", {15'd0, coef_update}, 16'd1);
    chk("commit_latency_w3", weights[3], 16'd4);
    step();
    chk("update_one_cycle", {15'd0, coef_update}, 16'd0);

    // Short load 5,6
    beat(16'd5, 1'b0);
    beat(16'd6, 1'b1);
    chk("short_err_s_ready", {15'd0, s_ready}, 16'd0);
    step();
    chk("short_load_err", {15'd0, load_err}, 16'd1);
    chk("short_s_ready_back", {15'd0, s_ready}, 16'd1);
    chk("short_w0_kept", weights[0], 16'd1);
    chk("short_w3_kept", weights[3], 16'd4);
    chk("short_coef_valid", {15'd0, coef_valid}, 16'd1);
    chk("short_checksum_kept", checksum, CK_EN ? 16'd10 : 16'd0);

    // Long load 7,8,9,10 with no s_last
    beat(16'd7, 1'b0);
    chk("new_load_clears_err", {15'd0, load_err}, 16'd0);
    beat(16'd8, 1'b0);
    beat(16'd9, 1'b0);
    beat(16'd10, 1'b0);
    chk("long_err_s_ready", {15'd0, s_ready}, 16'd0);
    step();
    chk("long_load_err", {15'd0, load_err}, 16'd1);
    chk("long_w1_kept", weights[1], 16'd2);

    // Held swap
    swap_ok = 1'b0;
    expect_commit(16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 16'h0000);
    beat(16'h7FFF, 1'b0);
    chk("next_load_clears_err", {15'd0, load_err}, 16'd0);
    beat(16'h8000, 1'b0);
    beat(16'h0000, 1'b0);
    beat(16'h0001, 1'b1);
    repeat (5) begin
      step();
      chk("held_s_ready", {15'd0, s_ready}, 16'd0);
      chk("held_no_update", {15'd0, coef_update}, 16'd0);
    end
    chk("held_w0_kept", weights[0], 16'd1);
    swap_ok = 1'b1;
    step();
    chk("held_commit_update", {15'd0, coef_update}, 16'd1);
    chk("held_commit_w1", weights[1], 16'h8000);
    step();

    // Back-pressure: s_valid follows a fixed irregular pattern, junk data when idle
    vals[0] = 16'd11;
    vals[1] = 16'd12;
    vals[2] = 16'd13;
    vals[3] = 16'd14;
    pat     = 16'b0110_1001_1100_1010;
    expect_commit(16'd11, 16'd12, 16'd13, 16'd14, 16'd50);
    k = 0;
    c = 0;
    while (k < 4 && c < 40) begin
      s_valid = pat[c % 16] | (c >= 16);
      s_coef  = s_valid ? vals[k] : 16'hDEAD;
      s_last  = (k == 3);
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      c++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("bp_beats_accepted", 16'(k), 16'd4);
    step();
    step();

    // Reset mid-load
    beat(16'd21, 1'b0);
    beat(16'd22, 1'b0);
    rst = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++) chk($sformatf("midrst_w%0d", i), weights[i], 16'd0);
    chk("midrst_coef_valid", {15'd0, coef_valid}, 16'd0);
    chk("midrst_coef_update", {15'd0, coef_update}, 16'd0);
    chk("midrst_s_ready", {15'd0, s_ready}, 16'd1);
    chk("midrst_load_err", {15'd0, load_err}, 16'd0);
    chk("midrst_checksum", checksum, 16'd0);
    rst = 1'b1;
    repeat (3) step();
    chk("midrst_no_update", {15'd0, coef_update}, 16'd0);

    // Fresh load after reset starts at slot 0
    expect_commit(16'd31, 16'd32, 16'd33, 16'd34, 16'd130);
    beat(16'd31, 1'b0);
    beat(16'd32, 1'b0);
    beat(16'd33, 1'b0);
    beat(16'd34, 1'b1);
    step();
    step();
    step();

    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_coef_loader.md
FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

Interface
REQ-001 SHALL have parameter TAPS, default 401, number of coefficients per bank.
REQ-002 SHALL have parameter COEFBITS, default 16, width of each coefficient.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-low reset.
REQ-005 SHALL have port s_valid, input, 1 bit, coefficient beat offered.
REQ-006 SHALL have port s_ready, output, 1 bit, loader can accept a beat.
REQ-007 SHALL have port s_coef, input, COEFBITS, signed coefficient value.
REQ-008 SHALL have port s_last, input, 1 bit, marks the final beat of a load.
REQ-009 SHALL have port swap_ok, input, 1 bit, high when the FIR may take new weights this cycle.
REQ-010 SHALL have port weights, output, array [0:TAPS-1] of COEFBITS, active bank driving the FIR in_weights.
REQ-011 SHALL have port coef_valid, output, 1 bit, active bank holds a committed load.
REQ-012 SHALL have port coef_update, output, 1 bit, one-cycle pulse on commit.
REQ-013 SHALL have port load_err, output, 1 bit, sticky length-mismatch flag.
REQ-014 SHALL have port checksum, output, 16 bits, sum of the committed bank (see Configuration).

Function
REQ-015 SHALL hold two banks: shadow (written by loads) and active (drives weights).
REQ-016 SHALL implement states IDLE, LOAD, SWAP, ERR.
REQ-017 SHALL drive s_ready=1 in IDLE and LOAD, and s_ready=0 in SWAP and ERR.
REQ-018 SHALL treat a beat as accepted only when s_valid and s_ready are both high at a clock edge.
REQ-019 SHALL write each accepted s_coef to shadow[idx] and then increment idx, where idx is 0 on the first beat.
REQ-020 SHALL go IDLE->LOAD on an accepted beat that does not end the load.
REQ-021 SHALL clear load_err on the first accepted beat of a new load.
REQ-022 SHALL go to SWAP on an accepted beat with s_last=1 and idx==TAPS-1, from IDLE when TAPS==1 or from LOAD otherwise.
REQ-023 SHALL go to ERR on an accepted beat with s_last=1 and idx<TAPS-1 (short load).
REQ-024 SHALL go to ERR on an accepted beat with s_last=0 and idx==TAPS-1 (long load); the idx counter SHALL never wrap.
REQ-025 SHALL, in ERR, set load_err=1, reset idx to 0, leave the active bank, coef_valid and checksum unchanged, and return to IDLE after exactly one cycle.
REQ-026 SHALL, in SWAP, wait with the active bank unchanged while swap_ok=0.
REQ-027 SHALL, in SWAP with swap_ok=1, copy shadow to active at that edge, set coef_valid=1, pulse coef_update high for the following cycle, reset idx to 0, and return to IDLE.
REQ-028 SHALL have a commit latency of one edge: with swap_ok held high, the last beat accepted at edge N makes the new weights visible after edge N+1.
REQ-029 SHALL never change the active bank except through the REQ-027 commit, so that no partial bank ever reaches the FIR.
REQ-030 SHALL ignore s_coef and s_last whenever s_ready=0.

Reset
REQ-031 SHALL, while rst=0 at a clock edge, set the state to IDLE and idx to 0.
REQ-032 SHALL, while rst=0 at a clock edge, set every shadow and active entry to 0.
REQ-033 SHALL, while rst=0 at a clock edge, set coef_valid=0, coef_update=0, load_err=0 and checksum=0; s_ready then follows from the IDLE state (1).
REQ-034 SHALL discard any load in progress on reset asserted mid-load or in SWAP, with no commit.

Configuration
REQ-035 SHALL, with FIR_COEF_CHECKSUM_EN defined, accumulate a running sum of accepted s_coef bits modulo 2^16 (sign ignored), cleared on the first beat of each load.
REQ-036 SHALL, with FIR_COEF_CHECKSUM_EN defined, latch that running sum into checksum at commit, and leave checksum unchanged on ERR.
REQ-037 SHALL, without FIR_COEF_CHECKSUM_EN, tie checksum to 0 and synthesize no accumulator logic.

Verification (TAPS=4)
REQ-038 SHALL verify a normal load: beats 1,2,3,4 with s_last on 4 and swap_ok=1 -> weights={1,2,3,4}, coef_update one cycle, coef_valid=1, checksum=10 with FIR_COEF_CHECKSUM_EN defined.
REQ-039 SHALL verify a short load: beats 5,6 with s_last on 6 -> load_err=1, weights stay {1,2,3,4}, s_ready low for one cycle.
REQ-040 SHALL verify a long load: beats 7,8,9,10 with s_last=0 on 10 -> ERR, load_err=1, weights unchanged, next load clears load_err.
REQ-041 SHALL verify a held swap: load 0x7FFF,0x8000,0,1 with swap_ok=0 for 5 cycles -> s_ready=0, weights unchanged; swap_ok=1 -> commit on next edge.
REQ-042 SHALL verify back-pressure: toggle s_valid randomly during a 4-beat load -> only handshaked beats are written, in order.
REQ-043 SHALL verify reset mid-load: rst=0 after 2 beats -> all weights 0, coef_valid=0, state IDLE, no coef_update.
